// File: rtl/async_oneway_receiver.sv
// ----------------------------------------------------------------------------
// async_oneway_receiver
//
// Receive end of the 6-bit asynchronous one-way link. Lives entirely in the
// clk_recv domain. The transmitter's chunk strobe and end-of-frame strobe come
// from clk_send. Each one passes through a synchronizer chain and then an edge
// detector. The 6-bit chunk bus travels through a parallel chain of the same
// depth, so the value sitting at the end of that chain lines up with the
// detected pulse edge. Chunks are assembled LSB-first into a MESSAGE_SIZE-bit
// datagram. The datagram is presented with a one-cycle valid strobe at the
// end of each frame.
//
// The receive clock must be at least twice the send clock.
//
// Parameters
//   MESSAGE_SIZE      datagram width in bits; matches the link constant (36).
//                     Must be greater than 6.
//   SYNC_STAGES       flops in each strobe synchronizer (>= 2)
//
// Ports
//   clk_recv          receive clock
//   rst_n             asynchronous active-low reset
//   packet_in         6-bit chunk data from the clk_send domain
//   packet_pulse_in   chunk strobe from the clk_send domain
//   transmit_ctrl_in  end-of-frame strobe from the clk_send domain
//   datagram_out      last accepted datagram, held until the next accept
//   datagram_valid    1-cycle strobe when datagram_out updates
//   frame_error       1-cycle strobe when a frame is rejected
//
// Configuration
//   RECV_FRAME_CHECK_EN  When defined, a frame is accepted only if it holds
//                        exactly NUM_CHUNKS chunks. Other frames are dropped
//                        and frame_error pulses. When undefined, every frame
//                        end delivers whatever is in the buffer, and
//                        frame_error is tied low.
// ----------------------------------------------------------------------------
module async_oneway_receiver #(
    parameter int MESSAGE_SIZE = 36,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk_recv,
    input  logic                    rst_n,
    input  logic [5:0]              packet_in,
    input  logic                    packet_pulse_in,
    input  logic                    transmit_ctrl_in,
    output logic [MESSAGE_SIZE-1:0] datagram_out,
    output logic                    datagram_valid,
    output logic                    frame_error
);

    localparam int NUM_CHUNKS = (MESSAGE_SIZE + 5) / 6;
    localparam int BUF_W      = NUM_CHUNKS * 6;

    typedef enum logic [1:0] {
        ST_SYNC,     // joined mid-frame: wait for a frame boundary
        ST_COLLECT,  // shifting chunks in
        ST_DELIVER   // one cycle: judge the frame and publish it
    } state_t;

    // ------------------------------------------------------------------------
    // Strobe synchronizers, edge detectors and the parallel data chain
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0]      pulse_sync;
    logic [SYNC_STAGES-1:0]      ctrl_sync;
    logic [SYNC_STAGES-1:0][5:0] data_sync;
    logic                        pulse_prev;
    logic                        ctrl_prev;
    logic                        pulse_rise;
    logic                        ctrl_rise;
    logic [5:0]                  chunk;

    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge and the chains shift one stage
    // per clock.
    always_ff @(posedge clk_recv or negedge rst_n) begin
        if (!rst_n) begin
            pulse_sync <= '0;
            ctrl_sync  <= '0;
            data_sync  <= '0;
            pulse_prev <= 1'b0;
            ctrl_prev  <= 1'b0;
        end else begin
            pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], packet_pulse_in};
            ctrl_sync  <= {ctrl_sync[SYNC_STAGES-2:0], transmit_ctrl_in};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], packet_in};
            pulse_prev <= pulse_sync[SYNC_STAGES-1];
            ctrl_prev  <= ctrl_sync[SYNC_STAGES-1];
        end
    end

    assign pulse_rise = pulse_sync[SYNC_STAGES-1] & ~pulse_prev;
    assign ctrl_rise  = ctrl_sync[SYNC_STAGES-1] & ~ctrl_prev;
    // The data was sampled on the same edge as the pulse, so it lines up with
    // pulse_rise.
    assign chunk      = data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------------
    // Frame FSM and assembly buffer
    // ------------------------------------------------------------------------
    state_t                  state, state_nxt;
    logic [BUF_W-1:0]        shift_buf, shift_buf_nxt;
    logic [MESSAGE_SIZE-1:0] datagram_nxt;
    logic                    valid_nxt;
    logic                    frame_end;

`ifdef RECV_FRAME_CHECK_EN
    localparam int CNT_W = $clog2(NUM_CHUNKS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CHUNKS);
    localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(NUM_CHUNKS + 1);

    logic [CNT_W-1:0] count, count_nxt;
    // A ctrl edge that arrives during DELIVER is remembered here. It closes
    // an empty frame on the next cycle.
    logic             ctrl_pend, ctrl_pend_nxt;
    logic             error_nxt;
`endif

    // NOTE: every variable is given a default before the case statement, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        shift_buf_nxt = shift_buf;
        datagram_nxt  = datagram_out;
        valid_nxt     = 1'b0;
`ifdef RECV_FRAME_CHECK_EN
        count_nxt     = count;
        ctrl_pend_nxt = ctrl_pend;
        error_nxt     = 1'b0;
        frame_end     = ctrl_rise | ctrl_pend;
`else
        frame_end     = ctrl_rise;
`endif

        unique case (state)
            ST_SYNC: begin
                // Pulses seen here belong to a frame that began before this
                // receiver was listening, so they are ignored.
                if (ctrl_rise) begin
                    state_nxt = ST_COLLECT;
`ifdef RECV_FRAME_CHECK_EN
                    count_nxt = '0;
`endif
                end
            end

            ST_COLLECT: begin
                // A chunk that arrives in the same cycle as the frame end is
                // shifted in first. DELIVER then judges the updated count.
                if (pulse_rise) begin
                    shift_buf_nxt = {chunk, shift_buf[BUF_W-1:6]};
`ifdef RECV_FRAME_CHECK_EN
                    if (count != CNT_OVF) count_nxt = count + CNT_W'(1);
`endif
                end
                if (frame_end) begin
                    state_nxt = ST_DELIVER;
`ifdef RECV_FRAME_CHECK_EN
                    ctrl_pend_nxt = 1'b0;
`endif
                end
            end

            ST_DELIVER: begin
`ifdef RECV_FRAME_CHECK_EN
                if (count == CNT_FULL) begin
                    datagram_nxt = shift_buf[MESSAGE_SIZE-1:0];
                    valid_nxt    = 1'b1;
                end else begin
                    error_nxt    = 1'b1;
                end
                count_nxt     = pulse_rise ? CNT_W'(1) : '0;
                ctrl_pend_nxt = ctrl_rise;
`else
                datagram_nxt = shift_buf[MESSAGE_SIZE-1:0];
                valid_nxt    = 1'b1;
`endif
                // The buffer is cleared for the next frame. A chunk that
                // arrives in this cycle becomes chunk 0 of that frame.
                shift_buf_nxt = pulse_rise ? {chunk, {(BUF_W-6){1'b0}}} : '0;
                state_nxt     = ST_COLLECT;
            end

            default: state_nxt = ST_SYNC;
        endcase
    end

    // NOTE: the assembly buffer is reset together with the control state.
    // A short frame after reset, in the unchecked build, therefore shows zero
    // fill rather than stale data.
    always_ff @(posedge clk_recv or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_SYNC;
            shift_buf      <= '0;
            datagram_out   <= '0;
            datagram_valid <= 1'b0;
`ifdef RECV_FRAME_CHECK_EN
            count          <= '0;
            ctrl_pend      <= 1'b0;
            frame_error    <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            shift_buf      <= shift_buf_nxt;
            datagram_out   <= datagram_nxt;
            datagram_valid <= valid_nxt;
`ifdef RECV_FRAME_CHECK_EN
            count          <= count_nxt;
            ctrl_pend      <= ctrl_pend_nxt;
            frame_error    <= error_nxt;
`endif
        end
    end

`ifndef RECV_FRAME_CHECK_EN
    assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_async_oneway_receiver.sv
// ----------------------------------------------------------------------------
// tb_async_oneway_receiver
//
// Directed bench for async_oneway_receiver with MESSAGE_SIZE=36 (6 chunks).
// clk_recv runs at 100 MHz. clk_send runs at 25 MHz and is offset by 3 ns, so
// transmitter activity never coincides with a receive edge. A negedge monitor
// logs every delivered datagram and every error strobe. The main sequence
// compares those logs with hand-computed values.
// ----------------------------------------------------------------------------
module tb_async_oneway_receiver;

    logic        clk_recv;
    logic        clk_send;
    logic        rst_n;
    logic [5:0]  packet_in;
    logic        packet_pulse_in;
    logic        transmit_ctrl_in;
    logic [35:0] datagram_out;
    logic        datagram_valid;
    logic        frame_error;

    async_oneway_receiver dut (
        .clk_recv         (clk_recv),
        .rst_n            (rst_n),
        .packet_in        (packet_in),
        .packet_pulse_in  (packet_pulse_in),
        .transmit_ctrl_in (transmit_ctrl_in),
        .datagram_out     (datagram_out),
        .datagram_valid   (datagram_valid),
        .frame_error      (frame_error)
    );

    initial begin
        clk_recv = 1'b0;
        forever #5 clk_recv = ~clk_recv;
    end

    initial begin
        clk_send = 1'b0;
        #3;
        forever #20 clk_send = ~clk_send;
    end

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------------
    // Monitor: log deliveries and error strobes, and flag any strobe that is
    // wider than one cycle.
    // ------------------------------------------------------------------------
    int          cyc        = 0;
    int          valid_cnt  = 0;
    int          err_cnt    = 0;
    int          valid_wide = 0;
    int          err_wide   = 0;
    int          valid_cyc  = 0;
    int          ctrl_cyc   = 0;
    logic        valid_d    = 1'b0;
    logic        err_d      = 1'b0;
    logic [35:0] got_q[$];

    always @(posedge clk_recv) cyc <= cyc + 1;

    always @(negedge clk_recv) begin
        valid_d <= datagram_valid;
        err_d   <= frame_error;
        if (datagram_valid === 1'b1) begin
            got_q.push_back(datagram_out);
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
            if (valid_d === 1'b1) valid_wide <= valid_wide + 1;
        end
        if (frame_error === 1'b1) begin
            err_cnt <= err_cnt + 1;
            if (err_d === 1'b1) err_wide <= err_wide + 1;
        end
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] got_at(input int idx);
        if (idx >= 0 && idx < got_q.size()) return got_q[idx];
        return 'x;
    endfunction

    // Sends n chunks of v, LSB chunk first, one pulse every two clk_send
    // cycles. When with_ctrl is set, ctrl rises one clk_send cycle after the
    // last pulse rise.
    task automatic send_frame(input logic [47:0] v, input int n, input bit with_ctrl);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_send);
            packet_in       = v[6*k +: 6];
            packet_pulse_in = 1'b1;
            @(posedge clk_send);
            packet_pulse_in = 1'b0;
        end
        if (with_ctrl) begin
            if (n == 0) @(posedge clk_send);
            transmit_ctrl_in = 1'b1;
            ctrl_cyc         = cyc;
            @(posedge clk_send);
            transmit_ctrl_in = 1'b0;
        end
    endtask

    task automatic wait_recv(input int n);
        repeat (n) @(posedge clk_recv);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    localparam logic [35:0] M1  = 36'h9_ABCD_1234;
    localparam logic [35:0] M2  = 36'h0_0000_0FFF;
    localparam logic [35:0] M5C = 36'h2_4681_3579;
    localparam logic [35:0] M7C = 36'h7_1357_9BDF;
    localparam logic [35:0] M55 = 36'h5_5555_5555;
    localparam logic [35:0] BA  = 36'hF_EDCB_A987;
    localparam logic [35:0] BB  = 36'h1_0203_0405;
    localparam logic [35:0] BC  = 36'h8_0000_0001;
    localparam logic [35:0] RF  = 36'hA_5A5A_5A5A;
    localparam logic [35:0] MR  = 36'h3_C3C3_C3C3;

    int          exp_valid = 0;
    int          exp_err   = 0;
    int          base;
    logic [35:0] exp_last;
    logic [35:0] tmp;

    initial begin
        rst_n            = 1'b0;
        packet_in        = 6'd0;
        packet_pulse_in  = 1'b0;
        transmit_ctrl_in = 1'b0;
        wait_recv(3);
        check("reset_datagram", 64'(datagram_out), 64'd0);
        check("reset_valid", 64'(datagram_valid), 64'd0);
        check("reset_error", 64'(frame_error), 64'd0);
        @(negedge clk_recv);
        rst_n = 1'b1;

        // Frame right after reset, with no earlier ctrl: it only closes the
        // join guard and must not be delivered.
        send_frame(48'(36'h1_2345_6789), 6, 1'b1);
        wait_recv(12);
        check("join_guard_no_valid", 64'(valid_cnt), 64'd0);
        check("join_guard_no_error", 64'(err_cnt), 64'd0);

        // First real frame: data, latency and strobe width.
        send_frame(48'(M1), 6, 1'b1);
        wait_recv(12);
        exp_valid++;
        check("m1_valid_count", 64'(valid_cnt), 64'(exp_valid));
        check("m1_data", 64'(got_at(exp_valid - 1)), 64'(M1));
        check("m1_latency", 64'(valid_cyc - ctrl_cyc), 64'd4);
        check("m1_held", 64'(datagram_out), 64'(M1));
        check("m1_valid_dropped", 64'(datagram_valid), 64'd0);
        check("m1_no_error", 64'(err_cnt), 64'd0);

        send_frame(48'(M2), 6, 1'b1);
        wait_recv(12);
        exp_valid++;
        check("m2_valid_count", 64'(valid_cnt), 64'(exp_valid));
        check("m2_data", 64'(got_at(exp_valid - 1)), 64'(M2));

        // Short frame: 5 chunks.
        send_frame(48'(M5C), 5, 1'b1);
        wait_recv(12);
`ifdef RECV_FRAME_CHECK_EN
        exp_err++;
        check("short_error", 64'(err_cnt), 64'(exp_err));
        check("short_no_valid", 64'(valid_cnt), 64'(exp_valid));
        check("short_keeps_data", 64'(datagram_out), 64'(M2));
`else
        exp_valid++;
        tmp      = M5C;
        exp_last = {tmp[29:0], 6'b000000};
        check("short_valid", 64'(valid_cnt), 64'(exp_valid));
        check("short_shifted_data", 64'(got_at(exp_valid - 1)), 64'(exp_last));
        check("short_error_tied", 64'(err_cnt), 64'd0);
`endif

        // Long frame: a leading junk chunk, then the 6 chunks of M7C.
        send_frame({M7C, 6'h2A}, 7, 1'b1);
        wait_recv(12);
`ifdef RECV_FRAME_CHECK_EN
        exp_err++;
        check("long_error", 64'(err_cnt), 64'(exp_err));
        check("long_no_valid", 64'(valid_cnt), 64'(exp_valid));
`else
        exp_valid++;
        check("long_valid", 64'(valid_cnt), 64'(exp_valid));
        check("long_last6_data", 64'(got_at(exp_valid - 1)), 64'(M7C));
`endif

        send_frame(48'(M55), 6, 1'b1);
        wait_recv(12);
        exp_valid++;
        check("m55_valid_count", 64'(valid_cnt), 64'(exp_valid));
        check("m55_data", 64'(got_at(exp_valid - 1)), 64'(M55));
        check("m55_error_count", 64'(err_cnt), 64'(exp_err));

        // Back-to-back frames at the transmitter's maximum rate.
        base = exp_valid;
        send_frame(48'(BA), 6, 1'b1);
        send_frame(48'(BB), 6, 1'b1);
        send_frame(48'(BC), 6, 1'b1);
        wait_recv(12);
        exp_valid += 3;
        check("b2b_valid_count", 64'(valid_cnt), 64'(exp_valid));
        check("b2b_first", 64'(got_at(base)), 64'(BA));
        check("b2b_second", 64'(got_at(base + 1)), 64'(BB));
        check("b2b_third", 64'(got_at(base + 2)), 64'(BC));
        check("b2b_error_count", 64'(err_cnt), 64'(exp_err));

        // Reset pulse in the middle of a frame, after chunk 3.
        send_frame(48'(RF), 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_datagram", 64'(datagram_out), 64'd0);
        check("midreset_valid", 64'(datagram_valid), 64'd0);
        check("midreset_error", 64'(frame_error), 64'd0);
        #10;
        rst_n = 1'b1;
        tmp = RF;
        send_frame(48'(tmp[35:18]), 3, 1'b1);
        wait_recv(12);
        check("midreset_remainder_ignored", 64'(valid_cnt), 64'(exp_valid));
        check("midreset_no_error", 64'(err_cnt), 64'(exp_err));
        send_frame(48'(MR), 6, 1'b1);
        wait_recv(12);
        exp_valid++;
        check("post_reset_valid", 64'(valid_cnt), 64'(exp_valid));
        check("post_reset_data", 64'(got_at(exp_valid - 1)), 64'(MR));

        check("valid_one_cycle", 64'(valid_wide), 64'd0);
        check("error_one_cycle", 64'(err_wide), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
